// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect bubbles, dmem waits.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_valid,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_redirect,
  input  logic        i_mem_req,
  input  logic        i_mem_ack,
  output logic        o_pc_stall,
  output logic        o_if_id_stall,
  output logic        o_id_ex_stall,
  output logic        o_ex_mem_stall,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic [1:0]  o_state,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIR = 2'd2} state_t;

  localparam logic [2:0] RB = REDIRECT_BUBBLES[2:0];

  state_t     state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic       lu, mw, redir_acc;

  assign lu = i_ex_valid && i_ex_mem_read && (i_ex_rd != 5'd0) &&
              ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
               (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));
  assign mw = i_mem_req && !i_mem_ack;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
      bcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      RUN: begin
        if (mw) state_d = MEM_WAIT;
        else if (i_ex_redirect && (RB != 3'd0)) begin
          state_d = REDIR;
          bcnt_d  = RB;
        end
      end
      MEM_WAIT: if (!mw) state_d = RUN;
      REDIR: begin
        // A memory wait freezes the bubble countdown; a fresh redirect restarts it.
        if (!mw) begin
          if (i_ex_redirect) bcnt_d = RB;
          else begin
            bcnt_d = bcnt_q - 3'd1;
            if (bcnt_q <= 3'd1) state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        bcnt_d  = 3'd0;
      end
    endcase
  end

  // Mealy outputs, forced low while reset is held so the pipeline sees no controls.
  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_ex_mem_stall = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    redir_acc      = 1'b0;
    if (i_reset) begin
      if (mw) begin
        o_pc_stall     = 1'b1;
        o_if_id_stall  = 1'b1;
        o_id_ex_stall  = 1'b1;
        o_ex_mem_stall = 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (i_ex_redirect) begin
              o_if_id_flush = 1'b1;
              o_id_ex_flush = 1'b1;
              redir_acc     = 1'b1;
            end else if (lu) begin
              o_pc_stall    = 1'b1;
              o_if_id_stall = 1'b1;
              o_id_ex_flush = 1'b1;
            end
          end
          REDIR: begin
            o_if_id_flush = 1'b1;
            if (i_ex_redirect) begin
              o_id_ex_flush = 1'b1;
              redir_acc     = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_stall_cnt <= 32'd0;
      o_flush_cnt <= 32'd0;
    end else begin
      if (o_pc_stall) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (redir_acc)  o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`else
  logic unused_acc;
  assign unused_acc  = redir_acc;
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl built with REDIRECT_BUBBLES=2.
module tb_hazard_ctrl;
  localparam int RB = 2;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [4:0]  i_id_rs1, i_id_rs2, i_ex_rd;
  logic        i_id_rs1_used, i_id_rs2_used, i_ex_valid, i_ex_mem_read;
  logic        i_ex_redirect, i_mem_req, i_mem_ack;
  logic        o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall;
  logic        o_if_id_flush, o_id_ex_flush;
  logic [1:0]  o_state;
  logic [31:0] o_stall_cnt, o_flush_cnt;

  always #5 i_clk = ~i_clk;

  hazard_ctrl #(.REDIRECT_BUBBLES(RB)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_ex_rd(i_ex_rd), .i_ex_valid(i_ex_valid), .i_ex_mem_read(i_ex_mem_read),
    .i_ex_redirect(i_ex_redirect), .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack),
    .o_pc_stall(o_pc_stall), .o_if_id_stall(o_if_id_stall),
    .o_id_ex_stall(o_id_ex_stall), .o_ex_mem_stall(o_ex_mem_stall),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_state(o_state), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       rs1u, rs2u;
    logic [4:0] rd;
    logic       v, mr, redir, req, ack;
  } in_t;

  // Expected vector: {pc, if_id, id_ex, ex_mem stalls, if_id flush, id_ex flush, state}
  localparam logic [7:0] Z   = 8'h00;
  localparam logic [7:0] W1  = 8'h01;
  localparam logic [7:0] SA  = 8'hF0;
  localparam logic [7:0] SA1 = 8'hF1;
  localparam logic [7:0] SA2 = 8'hF2;
  localparam logic [7:0] LU  = 8'hC4;
  localparam logic [7:0] RF  = 8'h0C;
  localparam logic [7:0] RF2 = 8'h0E;
  localparam logic [7:0] BF  = 8'h0A;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_STALLS = 32'd4;
  localparam logic [31:0] EXP_FLUSHES = 32'd1;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

  in_t        stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] sb[$];
  int         checks = 0;
  int         errors = 0;

  function automatic in_t mk(input int rs1, input int rs2, input bit rs1u, input bit rs2u,
                             input int rd, input bit v, input bit mr, input bit redir,
                             input bit req, input bit ack);
    in_t t;
    t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rs1u = rs1u; t.rs2u = rs2u; t.rd = 5'(rd);
    t.v = v; t.mr = mr; t.redir = redir; t.req = req; t.ack = ack;
    return t;
  endfunction

  function automatic logic [7:0] outs();
    return {o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall,
            o_if_id_flush, o_id_ex_flush, o_state};
  endfunction

  task automatic apply(input in_t t);
    i_id_rs1 = t.rs1; i_id_rs2 = t.rs2; i_id_rs1_used = t.rs1u; i_id_rs2_used = t.rs2u;
    i_ex_rd = t.rd; i_ex_valid = t.v; i_ex_mem_read = t.mr; i_ex_redirect = t.redir;
    i_mem_req = t.req; i_mem_ack = t.ack;
  endtask

  task automatic add(input in_t t, input logic [7:0] e);
    stim_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  in_t IDLE, LUI, REQ, REQACK, RED;

  task automatic test_reset();
    logic [7:0] e;
    i_reset = 1'b0;
    apply(REQ);
    sb.push_back(Z);
    #3;
    e = sb.pop_front();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset_outs got %b exp %b", outs(), e); end
    checks++;
    if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", o_stall_cnt, o_flush_cnt);
    end
    tick();
    i_reset = 1'b1;
    apply(IDLE);
    tick();
  endtask

  task automatic test_load_use();
    logic [7:0] e;
    int i = 0;
    add(LUI, LU);
    add(IDLE, Z);
    add(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0), Z);
    add(mk(7, 0, 1, 0, 7, 1, 1, 0, 0, 0), LU);
    add(mk(7, 0, 0, 0, 7, 1, 1, 0, 0, 0), Z);
    add(mk(0, 5, 0, 1, 5, 1, 0, 0, 0, 0), Z);
    add(mk(0, 5, 0, 1, 5, 0, 1, 0, 0, 0), Z);
    add(IDLE, Z);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      sb.push_back(exp_q.pop_front());
      @(negedge i_clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL load_use[%0d] got %b exp %b", i, outs(), e); end
      tick();
      i++;
    end
  endtask

  task automatic test_mem_wait();
    logic [7:0] e;
    int i = 0;
    add(REQ, SA);
    add(REQ, SA1);
    add(REQ, SA1);
    add(REQACK, W1);
    add(IDLE, Z);
    add(REQACK, Z);
    add(IDLE, Z);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      sb.push_back(exp_q.pop_front());
      @(negedge i_clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL mem_wait[%0d] got %b exp %b", i, outs(), e); end
      tick();
      i++;
    end
  endtask

  task automatic test_redirect();
    logic [7:0] e;
    int i = 0;
    add(RED, RF);  add(IDLE, BF); add(IDLE, BF); add(IDLE, Z);
    add(RED, RF);  add(RED, RF2); add(LUI, BF);  add(IDLE, BF); add(IDLE, Z);
    add(RED, RF);  add(REQ, SA2); add(IDLE, BF); add(IDLE, BF); add(IDLE, Z);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      sb.push_back(exp_q.pop_front());
      @(negedge i_clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL redirect[%0d] got %b exp %b", i, outs(), e); end
      tick();
      i++;
    end
  endtask

  task automatic test_priority();
    logic [7:0] e;
    int i = 0;
    add(mk(0, 5, 0, 1, 5, 1, 1, 1, 1, 0), SA);
    add(mk(0, 5, 0, 1, 5, 1, 1, 1, 1, 1), W1);
    add(mk(0, 5, 0, 1, 5, 1, 1, 1, 0, 0), RF);
    add(IDLE, BF);
    add(IDLE, BF);
    add(IDLE, Z);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      sb.push_back(exp_q.pop_front());
      @(negedge i_clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL priority[%0d] got %b exp %b", i, outs(), e); end
      tick();
      i++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    apply(REQ);
    tick();
    sb.push_back(SA1);
    @(negedge i_clk);
    e = sb.pop_front();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL rst_mw_pre got %b exp %b", outs(), e); end
    #2 i_reset = 1'b0;
    sb.push_back(Z);
    #1;
    e = sb.pop_front();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL rst_mw got %b exp %b", outs(), e); end
    tick();
    i_reset = 1'b1;
    apply(RED);
    tick();
    apply(IDLE);
    sb.push_back(BF);
    #1;
    e = sb.pop_front();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL rst_rd_pre got %b exp %b", outs(), e); end
    #1 i_reset = 1'b0;
    sb.push_back(Z);
    #1;
    e = sb.pop_front();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL rst_rd got %b exp %b", outs(), e); end
    tick();
    i_reset = 1'b1;
    tick();
    sb.push_back(Z);
    e = sb.pop_front();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL rst_after got %b exp %b", outs(), e); end
  endtask

  task automatic test_perf();
    i_reset = 1'b0;
    apply(IDLE);
    tick();
    i_reset = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin apply(REQ); tick(); end
    apply(REQACK); tick();
    apply(RED);    tick();
    for (int k = 0; k < 3; k++) begin apply(IDLE); tick(); end
    checks++;
    if (o_stall_cnt !== EXP_STALLS) begin
      errors++; $display("FAIL stall_cnt got %0d exp %0d", o_stall_cnt, EXP_STALLS);
    end
    checks++;
    if (o_flush_cnt !== EXP_FLUSHES) begin
      errors++; $display("FAIL flush_cnt got %0d exp %0d", o_flush_cnt, EXP_FLUSHES);
    end
  endtask

  initial begin
    IDLE   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    LUI    = mk(0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
    REQ    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    REQACK = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    RED    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect();
    test_priority();
    test_reset_mid();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. Generates the stall/flush controls for the PC, IF/ID, ID/EX and EX/MEM registers from load-use hazards, EX-stage redirects and data-memory wait handshakes. Sits beside the decode stage, and its outputs drive the `i_stall`/`i_flush` pins of the pipeline registers directly. It holds a small FSM so that multi-cycle memory waits and post-redirect fetch bubbles are sequenced without combinational loops through the pipeline.

## Interface
- `REDIRECT_BUBBLES`, default 1: extra cycles after a redirect during which IF/ID is flushed. This absorbs the synchronous imem latency. Legal range 0..7.
- `i_clk`  in  1  core clock
- `i_reset`  in  1  asynchronous, active-low reset
- `i_id_rs1`, `i_id_rs2`  in  5 each  source register indices of the instruction in ID
- `i_id_rs1_used`, `i_id_rs2_used`  in  1 each  source is actually read
- `i_ex_rd`  in  5  destination of the instruction in EX
- `i_ex_valid`  in  1  EX holds a real, non-bubble instruction
- `i_ex_mem_read`  in  1  EX instruction is a load
- `i_ex_redirect`  in  1  EX resolved a mispredict or jump; PC is being redirected this cycle
- `i_mem_req`  in  1  MEM stage has an outstanding data-memory access
- `i_mem_ack`  in  1  data memory completes the access this cycle
- `o_pc_stall`, `o_if_id_stall`, `o_id_ex_stall`, `o_ex_mem_stall`  out  1 each  hold the register
- `o_if_id_flush`, `o_id_ex_flush`  out  1 each  insert a bubble
- `o_state`  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 REDIRECT
- `o_stall_cnt`  out  32  performance counter (see Configuration)
- `o_flush_cnt`  out  32  performance counter (see Configuration)

## Operation
- Load-use hazard (`lu`):
  - Asserted when `i_ex_valid`, `i_ex_mem_read` and `i_ex_rd` != 0 are all true, and
  - `i_id_rs1_used` with `i_id_rs1` == `i_ex_rd`, or `i_id_rs2_used` with `i_id_rs2` == `i_ex_rd`.
- Memory wait (`mw`): `i_mem_req` && !`i_mem_ack`.
- The FSM state register and a 3-bit bubble counter `bcnt` are the only sequential state, apart from the optional counters.
- RUN, priority `mw` > `i_ex_redirect` > `lu`:
  - `mw`: assert all four stalls, no flushes, next state MEM_WAIT.
  - redirect: assert `o_if_id_flush` and `o_id_ex_flush`, no stalls. If `REDIRECT_BUBBLES`>0, load `bcnt`=`REDIRECT_BUBBLES` and go to REDIRECT; otherwise stay in RUN.
  - `lu`: assert `o_pc_stall`, `o_if_id_stall` and `o_id_ex_flush`. One bubble is inserted; the FSM stays in RUN.
  - Otherwise all outputs are 0.
- MEM_WAIT:
  - Assert all four stalls and no flushes while `mw`.
  - On `i_mem_ack`, deassert all outputs that cycle and return to RUN.
  - A redirect or `lu` present during the wait is evaluated in RUN once the wait ends. EX is frozen, so those inputs stay stable.
- REDIRECT:
  - If `mw`: assert all four stalls, do not assert `o_if_id_flush`, hold `bcnt`.
  - Otherwise assert `o_if_id_flush` and decrement `bcnt`. When `bcnt` reaches 1, return to RUN.
  - A new `i_ex_redirect` in REDIRECT reloads `bcnt` and also asserts `o_id_ex_flush`.
  - `lu` is ignored in REDIRECT, because ID holds a flushed bubble.
- Flush and stall are never both asserted on the same register in the same cycle.

## Timing
- Outputs are Mealy: combinational from state, `bcnt` and the current inputs, with zero-cycle latency.
- While `i_reset`=0: state=RUN, `bcnt`=0, all stall/flush outputs=0, `o_state`=0, counters=0.
- Reset is asynchronous on assert; release is sampled at the next `i_clk` rising edge.
- A load-use costs exactly 1 cycle.
- A redirect costs 1+`REDIRECT_BUBBLES` flushed IF/ID cycles, plus any memory-wait cycles.
- A memory access acked in its request cycle costs 0 cycles and causes no state change.
- Reset mid-MEM_WAIT or mid-REDIRECT returns to RUN immediately, with all outputs 0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `o_stall_cnt` increments every cycle `o_pc_stall`=1.
  - `o_flush_cnt` increments on every cycle `i_ex_redirect` is accepted (RUN or REDIRECT, not `mw`).
  - Both are 32-bit, wrap at 2^32, and are cleared by reset.
- Not defined: no counter logic is built; `o_stall_cnt` and `o_flush_cnt` are tied to 0.

## Test plan
- Load-use: `i_ex_valid`=1, `i_ex_mem_read`=1, `i_ex_rd`=5, `i_id_rs2`=5 with `i_id_rs2_used`=1 -> one cycle with `o_pc_stall`=`o_if_id_stall`=`o_id_ex_flush`=1; `i_ex_rd`=0 -> no stall.
- Memory wait: `i_mem_req`=1 with `i_mem_ack` low for 3 cycles, then high -> all stalls=1 for 3 cycles, `o_state`=1, then all outputs 0 and `o_state`=0.
- Redirect with `REDIRECT_BUBBLES`=2 -> cycle 0: both flushes; cycles 1-2: `o_if_id_flush` only with `o_state`=2; cycle 3: RUN and all outputs 0.
- Priority: `i_mem_req`=1, `i_mem_ack`=0, `i_ex_redirect`=1 and `lu` together -> stalls only. When the ack arrives, the redirect flush follows in the next cycle.
- Reset asserted in MEM_WAIT -> `o_state`=0 and all outputs 0 without a clock edge. With `HAZARD_PERF_CNT_EN`: 4 stall cycles and 1 redirect -> `o_stall_cnt`=4, `o_flush_cnt`=1.
